race_controller: RTL and testbench

RACE_CONTROLLER -- requirements
Module: race_controller

---
 rtl/race_controller.sv | 150 +++++++++++++++
 tb/tb_race_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/race_controller.sv
// rtl/race_controller.sv - start-light countdown, rpm/distance model and race FSM
// Gates raw shift pulses to the gear shifter and clamps the finish distance.
module race_controller #(
    parameter int          LIGHT_TICKS = 1000,
    parameter logic [15:0] FINISH_DIST = 16'd40000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_posedge,
    input  logic        shift_posedge,
    input  logic [1:0]  gear,
    output logic        reset_status,
    output logic        shift_out,
    output logic [1:0]  state,
    output logic [2:0]  lights,
    output logic [7:0]  rpm,
    output logic [15:0] distance,
    output logic [15:0] race_time,
    output logic        false_start
);

    localparam int             CW = $clog2(LIGHT_TICKS + 1);
    localparam logic [CW-1:0]  LT = CW'(LIGHT_TICKS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_RACE      = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
    logic [2:0]    lights_n;
    logic [7:0]    rpm_n, rpm_sat, inc;
    logic [8:0]    rpm_sum;
    logic [9:0]    prod;
    logic [15:0]   dist_n, time_n;
    logic [16:0]   dist_sum;
    logic          fs_n, shift_n, accept;

    assign state        = state_q;
    assign reset_status = (state_q == S_IDLE);

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        lights_n = lights;
        rpm_n    = rpm;
        dist_n   = distance;
        time_n   = race_time;
        fs_n     = false_start;
        shift_n  = 1'b0;

        cnt_inc  = cnt_q + 1'b1;
        accept   = shift_posedge && (gear != 2'd3);
        rpm_sum  = {1'b0, rpm} + {6'd0, 3'(3'd4 - {1'b0, gear})};
        rpm_sat  = rpm_sum[8] ? 8'hFF : rpm_sum[7:0];
        // Distance uses the rpm held before this cycle's update.
        prod     = ({8'd0, gear} + 10'd1) * {2'd0, rpm};
        inc      = prod[9:2];
        dist_sum = {1'b0, distance} + {9'd0, inc};

        case (state_q)
            S_IDLE: begin
                if (start_posedge) begin
                    state_n  = S_COUNTDOWN;
                    cnt_n    = '0;
                    lights_n = 3'b000;
                    rpm_n    = 8'd0;
                    dist_n   = 16'd0;
                    time_n   = 16'd0;
                    fs_n     = 1'b0;
                end
            end
            S_COUNTDOWN: begin
                if (start_posedge) begin
                    state_n = S_IDLE;
                end else if (shift_posedge) begin
                    fs_n    = 1'b1;
                    state_n = S_FINISH;
                end else if (tick) begin
                    if (cnt_inc == LT) begin
                        cnt_n = '0;
                        case (lights)
                            3'b000:  lights_n = 3'b001;
                            3'b001:  lights_n = 3'b011;
                            3'b011:  lights_n = 3'b111;
                            default: begin
                                lights_n = 3'b000;
                                state_n  = S_RACE;
                            end
                        endcase
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            S_RACE: begin
                if (start_posedge) begin
                    state_n = S_IDLE;
                end else begin
                    shift_n = accept;
                    // An accepted shift overrides the tick's rpm gain.
                    if (accept)
                        rpm_n = rpm >> 1;
                    else if (tick)
                        rpm_n = rpm_sat;
                    if (tick) begin
                        time_n = (race_time == 16'hFFFF) ? race_time : race_time + 16'd1;
                        if (dist_sum >= {1'b0, FINISH_DIST}) begin
                            dist_n  = FINISH_DIST;
                            state_n = S_FINISH;
                        end else begin
                            dist_n = dist_sum[15:0];
                        end
                    end
                end
            end
            default: begin
                if (start_posedge)
                    state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lights      <= 3'b000;
            rpm         <= 8'd0;
            distance    <= 16'd0;
            race_time   <= 16'd0;
            false_start <= 1'b0;
            shift_out   <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            lights      <= lights_n;
            rpm         <= rpm_n;
            distance    <= dist_n;
            race_time   <= time_n;
            false_start <= fs_n;
            shift_out   <= shift_n;
        end
    end

endmodule

// File: tb/tb_race_controller.sv
// tb/tb_race_controller.sv - directed self-checking bench for race_controller
module tb_race_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start_posedge = 1'b0;
    logic        shift_posedge = 1'b0;
    logic [1:0]  gear = 2'd0;

    logic        reset_status, shift_out, false_start;
    logic [1:0]  state;
    logic [2:0]  lights;
    logic [7:0]  rpm;
    logic [15:0] distance, race_time;

    logic        f_reset_status, f_shift_out, f_false_start;
    logic [1:0]  f_state;
    logic [2:0]  f_lights;
    logic [7:0]  f_rpm;
    logic [15:0] f_distance, f_race_time;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    race_controller #(.LIGHT_TICKS(2), .FINISH_DIST(16'hFFFF)) u_dut (
        .clk(clk), .rst(rst), .tick(tick), .start_posedge(start_posedge),
        .shift_posedge(shift_posedge), .gear(gear), .reset_status(reset_status),
        .shift_out(shift_out), .state(state), .lights(lights), .rpm(rpm),
        .distance(distance), .race_time(race_time), .false_start(false_start)
    );

    race_controller #(.LIGHT_TICKS(2), .FINISH_DIST(16'd100)) u_fin (
        .clk(clk), .rst(rst), .tick(tick), .start_posedge(start_posedge),
        .shift_posedge(shift_posedge), .gear(gear), .reset_status(f_reset_status),
        .shift_out(f_shift_out), .state(f_state), .lights(f_lights), .rpm(f_rpm),
        .distance(f_distance), .race_time(f_race_time), .false_start(f_false_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic pulse_start();
        start_posedge = 1'b1;
        cycle();
        start_posedge = 1'b0;
    endtask

    task automatic pulse_shift();
        shift_posedge = 1'b1;
        cycle();
        shift_posedge = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic to_race();
        pulse_start();
        for (int i = 0; i < 8; i++) pulse_tick();
    endtask

    initial begin
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_status", reset_status, 1);
        chk("rst_lights", lights, 0);
        chk("rst_rpm", rpm, 0);
        chk("rst_dist", distance, 0);
        chk("rst_time", race_time, 0);
        chk("rst_fs", false_start, 0);
        chk("rst_shift", shift_out, 0);

        tick = 1'b1; shift_posedge = 1'b1;
        cycle();
        tick = 1'b0; shift_posedge = 1'b0;
        chk("idle_ignore_state", state, 0);
        chk("idle_ignore_shift", shift_out, 0);

        pulse_start();
        chk("cd_state", state, 1);
        chk("cd_status", reset_status, 0);
        pulse_tick();
        chk("cd_t1_lights", lights, 3'b000);
        pulse_tick();
        chk("cd_t2_lights", lights, 3'b001);
        pulse_tick();
        pulse_tick();
        chk("cd_t4_lights", lights, 3'b011);
        pulse_tick();
        pulse_tick();
        chk("cd_t6_lights", lights, 3'b111);
        chk("cd_t6_state", state, 1);
        pulse_tick();
        pulse_tick();
        chk("cd_t8_lights", lights, 3'b000);
        chk("cd_t8_state", state, 2);

        gear = 2'd0;
        for (int i = 0; i < 10; i++) pulse_tick();
        chk("rpm_10ticks", rpm, 40);
        chk("dist_10ticks", distance, 45);
        chk("time_10ticks", race_time, 10);
        pulse_shift();
        chk("shift_out_hi", shift_out, 1);
        chk("rpm_halved", rpm, 20);
        cycle();
        chk("shift_out_lo", shift_out, 0);

        gear = 2'd3;
        pulse_shift();
        chk("gate_shift_out", shift_out, 0);
        chk("gate_rpm", rpm, 20);
        for (int i = 0; i < 300; i++) pulse_tick();
        chk("rpm_sat", rpm, 255);
        chk("time_310", race_time, 310);
        chk("dist_sat_run", distance, 48815);
        chk("sat_state", state, 2);

        do_reset();
        chk("mid_rst_state", state, 0);
        chk("mid_rst_status", reset_status, 1);
        chk("mid_rst_rpm", rpm, 0);
        chk("mid_rst_dist", distance, 0);
        chk("mid_rst_time", race_time, 0);
        chk("mid_rst_lights", lights, 0);
        chk("mid_rst_shift", shift_out, 0);
        chk("mid_rst_fs", false_start, 0);

        gear = 2'd0;
        to_race();
        chk("abort_pre_state", state, 2);
        pulse_start();
        chk("abort_state", state, 0);
        chk("abort_status", reset_status, 1);

        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) pulse_tick();
        chk("fs_lights_011", lights, 3'b011);
        pulse_shift();
        chk("fs_state", state, 3);
        chk("fs_flag", false_start, 1);
        chk("fs_shift_out", shift_out, 0);
        chk("fs_status", reset_status, 0);
        pulse_tick();
        pulse_tick();
        chk("fs_lights_hold", lights, 3'b011);
        chk("fs_shift_out_later", shift_out, 0);

        do_reset();
        gear = 2'd1;
        to_race();
        chk("fin_race", f_state, 2);
        for (int i = 0; i < 12; i++) pulse_tick();
        chk("fin_dist_12", f_distance, 96);
        chk("fin_state_12", f_state, 2);
        pulse_tick();
        chk("fin_dist_clamp", f_distance, 100);
        chk("fin_state", f_state, 3);
        chk("fin_time", f_race_time, 13);
        for (int i = 0; i < 3; i++) pulse_tick();
        chk("fin_time_hold", f_race_time, 13);
        chk("fin_dist_hold", f_distance, 100);
        chk("fin_rpm_hold", f_rpm, 39);
        pulse_start();
        chk("fin_idle", f_state, 0);
        chk("fin_status", f_reset_status, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
